aes_v1: RTL and testbench



---
 rtl/aes_v1.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_aes_v1.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_v1.sv
// aes_v1: AXI wrapper around the iterative AES-128 core aes_module.
// AXI4-Lite register file (CTRL, STATUS, BLOCK_COUNT, SCRATCH).
// The 128-bit block arrives as four AXIS beats and leaves as four AXIS beats, big-endian.
// Optional feature macro: AES_BLOCK_COUNTER_EN (BLOCK_COUNT register and incrementer).
// Also contains aes_module. Its reset is active low, and its mode is
// 0 encrypt, 1 decrypt, 2 expand key.

module aes_module (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] din,
  output logic [127:0] dout,
  input  logic [1:0]   mode,
  input  logic         aes_start,
  output logic         aes_done
);
  localparam logic [3:0] LAT_KEY  = 4'd13;
  localparam logic [3:0] LAT_CIPH = 4'd14;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01; p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  // Byte i of the state is row i%4, column i/4, and byte 0 is the MSB.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (!last) begin
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]) ^ k[127-8*(r+4*c) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (!last) begin
        t[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        t[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        t[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        t[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rcon);
    logic [31:0] rw, t, n0, n1, n2, n3;
    rw = {p[23:0], p[31:24]};
    t  = {sbox(rw[31:24]) ^ rcon, sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    n0 = p[127:96] ^ t;
    n1 = p[95:64] ^ n0;
    n2 = p[63:32] ^ n1;
    n3 = p[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st_q, st_d;
  logic [127:0] rk_q [0:10];
  logic [3:0]   cnt_q, cnt_d, r_idx;
  logic [7:0]   rcon_q, rcon_d;
  logic [1:0]   op_q, op_d;
  logic         busy_q, busy_d, done_q, done_d, sprev_q;
  logic         rk_we;
  logic [3:0]   rk_idx;
  logic [127:0] rk_wdata;
  logic         start_rise;

  assign start_rise = aes_start & ~sprev_q;
  assign dout       = st_q;
  assign aes_done   = done_q;

  // A rising edge of aes_start restarts the core. Rounds 1..10 run one per cycle,
  // and the remaining cycles are idle.
  always_comb begin
    st_d = st_q; cnt_d = cnt_q; busy_d = busy_q; done_d = done_q;
    rcon_d = rcon_q; op_d = op_q;
    rk_we = 1'b0; rk_idx = 4'd0; rk_wdata = '0;
    r_idx = (cnt_q > 4'd10) ? 4'd10 : cnt_q;
    if (start_rise) begin
      cnt_d = 4'd1; busy_d = 1'b1; done_d = 1'b0; rcon_d = 8'h01;
      op_d  = (mode == 2'd3) ? 2'd0 : mode;
      if (mode == 2'd2) begin
        rk_we = 1'b1; rk_idx = 4'd0; rk_wdata = din;
      end else if (mode == 2'd1) st_d = din ^ rk_q[10];
      else                       st_d = din ^ rk_q[0];
    end else if (busy_q) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q <= 4'd10) begin
        case (op_q)
          2'd1: st_d = dec_round(st_q, rk_q[4'd10 - r_idx], cnt_q == 4'd10);
          2'd2: begin
            rk_we = 1'b1; rk_idx = cnt_q;
            rk_wdata = key_step(rk_q[cnt_q - 4'd1], rcon_q);
            rcon_d = xt(rcon_q);
          end
          default: st_d = enc_round(st_q, rk_q[r_idx], cnt_q == 4'd10);
        endcase
      end
      if (cnt_q == ((op_q == 2'd2) ? LAT_KEY - 4'd1 : LAT_CIPH - 4'd1)) begin
        busy_d = 1'b0; done_d = 1'b1;
      end
    end
  end

  // Core state and the round-key store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= '0; cnt_q <= '0; rcon_q <= '0; op_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; sprev_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; rcon_q <= rcon_d; op_q <= op_d;
      busy_q <= busy_d; done_q <= done_d; sprev_q <= aes_start;
      if (rk_we) rk_q[rk_idx] <= rk_wdata;
    end
  end
endmodule

module aes_v1 #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int C_AXIS_TDATA_WIDTH   = 32
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  output logic                              aes_done,
  output logic                              status_0,
  output logic                              status_1
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_SEND} state_e;

  state_e       state_q, state_d;
  logic [1:0]   ibeat_q, ibeat_d, obeat_q, obeat_d;
  logic [127:0] din_q, din_d, osh_q, osh_d;
  logic [1:0]   op_q, op_d, mode_q, mode_d;
  logic         kv_q, kv_d, start_q, start_d, mval_q, mval_d, srdy_q, srdy_d;
  logic         busy_q, done_q;
  logic [31:0]  scratch_q, scratch_d, rdata_q, rdata_d;
  logic         awrdy_q, awrdy_d, bvalid_q, bvalid_d, arrdy_q, arrdy_d, rvalid_q, rvalid_d;
  logic [127:0] core_dout;
  logic         core_done;
  logic         wr_fire, rd_fire, clr, s_fire, m_fire;
  logic [31:0]  bcnt_rd;
`ifdef AES_BLOCK_COUNTER_EN
  logic [31:0]  bcnt_q, bcnt_d;
`endif
  logic         unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], s00_axis_tstrb, s00_axis_tlast};

  aes_module u_core (
    .clk(s00_axi_aclk), .reset(s00_axi_aresetn), .din(din_q), .dout(core_dout),
    .mode(op_q), .aes_start(start_q), .aes_done(core_done)
  );

  assign wr_fire = s00_axi_awvalid & awrdy_q & s00_axi_wvalid;
  assign rd_fire = s00_axi_arvalid & arrdy_q;
  assign clr     = wr_fire & (s00_axi_awaddr[3:2] == 2'd0) & s00_axi_wstrb[0] & s00_axi_wdata[2];
  assign s_fire  = s00_axis_tvalid & srdy_q;
  assign m_fire  = mval_q & m00_axis_tready;

`ifdef AES_BLOCK_COUNTER_EN
  assign bcnt_rd = bcnt_q;
`else
  assign bcnt_rd = 32'd0;
`endif

  assign s00_axi_awready = awrdy_q;
  assign s00_axi_wready  = awrdy_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arrdy_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axis_tready = srdy_q;
  assign m00_axis_tdata  = osh_q[127:96];
  assign m00_axis_tvalid = mval_q;
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tlast  = mval_q & (obeat_q == 2'd3);
  assign aes_done        = done_q;
  assign status_0        = kv_q;
  assign status_1        = busy_q;

  // AXI-Lite handshakes and register writes; reads capture data on the address handshake.
  always_comb begin
    awrdy_d   = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awrdy_q;
    bvalid_d  = wr_fire ? 1'b1 : (s00_axi_bready ? 1'b0 : bvalid_q);
    arrdy_d   = s00_axi_arvalid & ~arrdy_q & ~rvalid_q;
    rvalid_d  = rd_fire ? 1'b1 : (s00_axi_rready ? 1'b0 : rvalid_q);
    rdata_d   = rdata_q;
    mode_d    = mode_q;
    scratch_d = scratch_q;
    if (wr_fire && s00_axi_awaddr[3:2] == 2'd0 && s00_axi_wstrb[0]) mode_d = s00_axi_wdata[1:0];
    if (wr_fire && s00_axi_awaddr[3:2] == 2'd3)
      for (int i = 0; i < 4; i++)
        if (s00_axi_wstrb[i]) scratch_d[8*i +: 8] = s00_axi_wdata[8*i +: 8];
    if (rd_fire)
      case (s00_axi_araddr[3:2])
        2'd0:    rdata_d = {30'd0, mode_q};
        2'd1:    rdata_d = {29'd0, kv_q, done_q, busy_q};
        2'd2:    rdata_d = bcnt_rd;
        default: rdata_d = scratch_q;
      endcase
  end

  // Block FSM: gather four beats, run the core, drain four beats. A clear overrides everything.
  always_comb begin
    state_d = state_q; ibeat_d = ibeat_q; obeat_d = obeat_q;
    din_d = din_q; osh_d = osh_q; op_d = op_q; kv_d = kv_q;
    start_d = start_q; mval_d = mval_q;
`ifdef AES_BLOCK_COUNTER_EN
    bcnt_d = bcnt_q;
`endif
    case (state_q)
      S_IDLE, S_LOAD: if (s_fire) begin
        din_d   = {din_q[95:0], s00_axis_tdata};
        ibeat_d = ibeat_q + 2'd1;
        state_d = S_LOAD;
        if (ibeat_q == 2'd3) begin
          state_d = S_START; start_d = 1'b1;
          op_d    = (mode_q == 2'd3) ? 2'd0 : mode_q;
        end
      end
      // start already high here, so the core sees a fresh rising edge and drops its old done
      S_START: state_d = S_RUN;
      S_RUN: if (core_done) begin
        start_d = 1'b0;
        if (op_q == 2'd2) begin
          kv_d = 1'b1; state_d = S_IDLE;
        end else begin
          osh_d = core_dout; obeat_d = 2'd0; mval_d = 1'b1; state_d = S_SEND;
        end
      end
      S_SEND: if (m_fire) begin
        osh_d   = {osh_q[95:0], 32'd0};
        obeat_d = obeat_q + 2'd1;
        if (obeat_q == 2'd3) begin
          mval_d = 1'b0; state_d = S_IDLE;
`ifdef AES_BLOCK_COUNTER_EN
          bcnt_d = bcnt_q + 32'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE; ibeat_d = 2'd0; mval_d = 1'b0; kv_d = 1'b0; start_d = 1'b0;
    end
    // Cipher modes need a key before any beat is accepted
    srdy_d = (state_d == S_IDLE || state_d == S_LOAD) && (mode_d == 2'd2 || kv_d);
  end

  // All wrapper state
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= S_IDLE; ibeat_q <= '0; obeat_q <= '0; din_q <= '0; osh_q <= '0;
      op_q <= '0; mode_q <= '0; kv_q <= 1'b0; start_q <= 1'b0; mval_q <= 1'b0;
      srdy_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; scratch_q <= '0; rdata_q <= '0;
      awrdy_q <= 1'b0; bvalid_q <= 1'b0; arrdy_q <= 1'b0; rvalid_q <= 1'b0;
`ifdef AES_BLOCK_COUNTER_EN
      bcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d; ibeat_q <= ibeat_d; obeat_q <= obeat_d; din_q <= din_d;
      osh_q <= osh_d; op_q <= op_d; mode_q <= mode_d; kv_q <= kv_d; start_q <= start_d;
      mval_q <= mval_d; srdy_q <= srdy_d; busy_q <= (state_d != S_IDLE);
      done_q <= core_done; scratch_q <= scratch_d; rdata_q <= rdata_d;
      awrdy_q <= awrdy_d; bvalid_q <= bvalid_d; arrdy_q <= arrdy_d; rvalid_q <= rvalid_d;
`ifdef AES_BLOCK_COUNTER_EN
      bcnt_q <= bcnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_aes_v1.sv
// Bench for aes_v1: FIPS-197 known-answer blocks, random encrypt/decrypt round trips
// with random output backpressure, register-file behaviour, reset and clear aborts.
module tb_aes_v1;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, s_tstrb, m_tstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic        done_o, st0, st1;

  int checks = 0;
  int failures = 0;
  int blocks = 0;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_v1 dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
    .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast), .aes_done(done_o),
    .status_0(st0), .status_1(st1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
    check("axi_aw_timeout", 128'(n >= 50), 128'd0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check("axi_b_timeout", 128'(n >= 50), 128'd0);
    check("axi_bresp", 128'(bresp), 128'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    check("axi_r_timeout", 128'(n >= 100), 128'd0);
    check("axi_rresp", 128'(rresp), 128'd0);
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, 128'(d), 128'(exp));
  endtask

  // Feed the first n words of blk, MSW first
  task automatic send_beats(input logic [127:0] blk, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tdata = blk[127-32*i -: 32]; s_tvalid = 1'b1;
      k = 0;
      while (!s_tready && k < 100) begin @(negedge clk); k++; end
      check("s_beat_timeout", 128'(k >= 100), 128'd0);
      @(posedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // Collect four beats. Under random backpressure, a stalled beat must hold valid and data.
  task automatic recv_block(input bit rnd, output logic [127:0] data, output logic [3:0] lasts);
    int got, n;
    logic pv, pr;
    logic [31:0] pd;
    got = 0; n = 0; pv = 1'b0; pr = 1'b0; pd = '0; data = '0; lasts = '0;
    while (got < 4 && n < 400) begin
      @(negedge clk); n++;
      if (pv && !pr) begin
        check("m_hold_valid", 128'(m_tvalid), 128'd1);
        check("m_hold_data", 128'(m_tdata), 128'(pd));
      end
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        data[127-32*got -: 32] = m_tdata;
        lasts[got] = m_tlast;
        got++;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata;
    end
    check("m_recv_timeout", 128'(got), 128'd4);
    @(negedge clk);
    m_tready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (st1 && n < 200) begin @(negedge clk); n++; end
    check("idle_timeout", 128'(n >= 200), 128'd0);
  endtask

  task automatic run_block(input logic [1:0] mode, input logic [127:0] blk, input bit rnd,
                           output logic [127:0] res);
    logic [3:0] lasts;
    axi_write(4'h0, {30'd0, mode});
    send_beats(blk, 4);
    recv_block(rnd, res, lasts);
    check("tlast_pattern", 128'(lasts), 128'(4'b1000));
    blocks++;
  endtask

  function automatic logic [31:0] exp_count(input int b);
`ifdef AES_BLOCK_COUNTER_EN
    return 32'(b);
`else
    return 32'd0 & 32'(b);
`endif
  endfunction

  initial begin
    logic [127:0] res, pt, ct;
    logic [31:0]  v;
    int           seen;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; awvalid = 1'b0; wvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tstrb = 4'hF; s_tlast = 1'b0; m_tready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          128'({s_tready, m_tvalid, m_tlast, done_o, st0, st1, awready, wready, bvalid,
                arready, rvalid}), 128'd0);
    check("reset_m_tdata", 128'(m_tdata), 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("tready_no_key", 128'(s_tready), 128'd0);

    read_check("ctrl_reset", 4'h0, 32'd0);
    read_check("status_reset", 4'h4, 32'd0);
    read_check("bcount_reset", 4'h8, 32'd0);
    read_check("scratch_reset", 4'hC, 32'd0);

    // Clear bit is self-clearing and bits above [1:0] do not stick
    axi_write(4'h0, 32'h0000_00C8);
    read_check("ctrl_c8", 4'h0, 32'd0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (s_tready) seen++; end
    check("tready_stays_low", 128'(seen), 128'd0);
    check("status0_no_key", 128'(st0), 128'd0);

    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      axi_write(4'hC, v);
      read_check("scratch_rw", 4'hC, v);
    end
    axi_write(4'h4, $urandom);
    axi_write(4'h8, $urandom);
    read_check("status_ro", 4'h4, 32'd0);
    read_check("bcount_ro", 4'h8, 32'd0);

    // Key expansion: sets key_valid and produces no output beats
    axi_write(4'h0, 32'd2);
    send_beats(KEY, 4);
    seen = 0;
    repeat (40) begin @(negedge clk); if (m_tvalid) seen++; end
    check("expand_no_output", 128'(seen), 128'd0);
    check("status0_after_key", 128'(st0), 128'd1);
    read_check("status_after_key", 4'h4, 32'h6);

    run_block(2'd0, PT, 1'b0, res);
    check("kat_encrypt", res, CT);
    run_block(2'd1, CT, 1'b1, res);
    check("kat_decrypt", res, PT);
    read_check("bcount_after_kat", 4'h8, exp_count(blocks));

    // Random round trips under random backpressure; mode 3 behaves as encrypt
    for (int i = 0; i < 3; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block((i == 1) ? 2'd3 : 2'd0, pt, 1'b1, ct);
      run_block(2'd1, ct, 1'b1, res);
      check("roundtrip", res, pt);
    end
    read_check("bcount_after_rand", 4'h8, exp_count(blocks));

    // A mode change while busy applies to the next block only
    axi_write(4'h0, 32'd0);
    send_beats(PT, 4);
    axi_write(4'h0, 32'd1);
    begin
      logic [3:0] lasts;
      recv_block(1'b0, res, lasts);
    end
    blocks++;
    check("mode_change_busy", res, CT);
    repeat (2) @(negedge clk);
    check("tready_after_mode_change", 128'(s_tready), 128'd1);

    // Reset during RUN aborts at once
    axi_write(4'h0, 32'd0);
    send_beats(PT, 4);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outputs",
             128'({s_tready, m_tvalid, done_o, st0, st1, awready, bvalid, arready, rvalid}),
             128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    blocks = 0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (m_tvalid || s_tready) seen++; end
    check("post_reset_quiet", 128'(seen), 128'd0);
    check("post_reset_status0", 128'(st0), 128'd0);
    read_check("post_reset_bcount", 4'h8, 32'd0);

    // Clear after two beats discards them; the next four beats form a fresh key
    axi_write(4'h0, 32'd2);
    send_beats(KEY, 4);
    wait_idle();
    check("key_before_clear", 128'(st0), 128'd1);
    send_beats({$urandom, $urandom, 64'd0}, 2);
    check("busy_partial", 128'(st1), 128'd1);
    axi_write(4'h0, 32'd6);
    repeat (2) @(negedge clk);
    check("clear_idle", 128'(st1), 128'd0);
    check("clear_key_valid", 128'(st0), 128'd0);
    read_check("clear_selfclear", 4'h0, 32'd2);
    send_beats(KEY, 4);
    wait_idle();
    check("fresh_key_valid", 128'(st0), 128'd1);
    run_block(2'd0, PT, 1'b1, res);
    check("encrypt_after_clear", res, CT);
    read_check("bcount_final", 4'h8, exp_count(blocks));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
